rnn_host_if: RTL and testbench
==============================

RNN_HOST_IF -- requirements
Module: rnn_host_if

Interface
REQ-001 clk  input  1  rising-edge clock; reset  input  1  synchronous, active-high.
REQ-002 host_start  input  1  single-cycle run-request pulse.
REQ-003 host_seq_len  input  11  timestep count returned on the t_count read.
REQ-004 in_valid/in_ready  input/output  1/1  host input-word handshake; in_data  input  32.
REQ-005 ready  output  1  start request to the accelerator; busy  input  1  accelerator running.
REQ-006 i_en  input  1  accelerator input-word request; idata  output  32  input word.
REQ-007 mce  input  1  memory enable; msel  input  3  region select; maddr  input  17  region address.
REQ-008 mdata_w  input  20  write data; mdata_r  output  20  read data.
REQ-009 sram_ce, sram_we  output  1  external SRAM strobes; sram_addr  output  19; sram_wdata  output  20; sram_rdata  input  20, 1-cycle latency.
REQ-010 done  output  1  run-complete pulse; wr_count  output  17  result writes this run; err  output  1  sticky error.

Function
REQ-011 Region map (mce=1): 000 W_ih -> sram_addr 0x00000+maddr[10:0]; 010 W_hh -> 0x00800+maddr[11:0]; 001 b_ih -> 0x01800+maddr[5:0]; 011 b_hh -> 0x01840+maddr[5:0]; 101 result -> 0x02000+maddr; 100 t_count -> register, no SRAM access; 110/111 invalid.
REQ-012 sram_ce/sram_addr/sram_we/sram_wdata shall be combinational from the mce/msel/maddr/mdata_w inputs of the same cycle.
REQ-013 Read regions (000, 001, 010, 011) assert sram_ce with sram_we=0; mdata_r shall equal sram_rdata in the cycle after the request (1-cycle latency).
REQ-014 msel=100 shall cause mdata_r={9'b0,host_seq_len} in the following cycle, with sram_ce=0.
REQ-015 msel=101 shall assert sram_ce=1, sram_we=1, sram_wdata=mdata_w and increment wr_count (saturating at 0x1FFFF); mdata_r shall hold its value.
REQ-016 msel 110/111 with mce=1 shall set err, assert no SRAM strobe, and drive mdata_r=0 in the next cycle.
REQ-017 With mce=0, no strobes shall be asserted and mdata_r shall hold its value.
REQ-018 Input FIFO: 4 entries; in_ready=!full; a push occurs when in_valid&in_ready.
REQ-019 On a cycle with i_en=1 and the FIFO non-empty, the head shall be popped into the idata register, visible from the next cycle.
REQ-020 A same-cycle push and pop shall be legal, including when full, with occupancy unchanged.
REQ-021 i_en=1 with the FIFO empty shall set err and leave idata unchanged; pointers shall wrap modulo 4.
REQ-022 FSM states: IDLE, ARM, RUN. IDLE->ARM on host_start (wr_count cleared). ARM drives ready=1. ARM->RUN when busy=1, after which ready=0. RUN->IDLE when busy=0, with done=1 for exactly that one cycle.
REQ-023 host_start outside IDLE shall be ignored.

Reset
REQ-024 On reset: ready=0, done=0, err=0, wr_count=0, mdata_r=0, idata=0, FIFO empty (in_ready=1), FSM=IDLE.
REQ-025 Reset asserted mid-run shall take priority over all other events and abort the run with no done pulse.

Structure
REQ-026 A shared package shall hold the msel region codes, the region base addresses, the FIFO depth and the FSM state enum.
REQ-027 The input FIFO shall be a sub-module, word_fifo4.

Verification
REQ-028 Read W_hh: mce=1, msel=010, maddr=0x005, sram_rdata=0x12345 -> sram_addr=0x00805 the same cycle; mdata_r=0x12345 the next cycle.
REQ-029 t_count read: host_seq_len=9, msel=100 -> mdata_r=0x00009 the next cycle; sram_ce=0.
REQ-030 Result write: msel=101, maddr=0x00041, mdata_w=0xF0000 -> sram_we=1, sram_addr=0x02041, sram_wdata=0xF0000; wr_count 0->1.
REQ-031 FIFO: push A,B,C,D -> in_ready=0; i_en plus push E in the same cycle -> idata=A, in_ready remains 0; four further pops -> B,C,D,E; a fifth pop -> err=1, idata=E.
REQ-032 Handshake: host_start -> ready=1; busy rises 3 cycles later -> ready=0; busy falls -> one-cycle done; msel=111 -> err=1; reset -> all outputs as in REQ-024.

Source files
------------

// File: rtl/rnn_host_if_pkg.sv
// rtl/rnn_host_if_pkg.sv - shared region codes, SRAM base addresses, FIFO sizing and FSM states
package rnn_host_if_pkg;

  localparam logic [2:0] MSEL_W_IH   = 3'b000;
  localparam logic [2:0] MSEL_B_IH   = 3'b001;
  localparam logic [2:0] MSEL_W_HH   = 3'b010;
  localparam logic [2:0] MSEL_B_HH   = 3'b011;
  localparam logic [2:0] MSEL_TCNT   = 3'b100;
  localparam logic [2:0] MSEL_RESULT = 3'b101;

  localparam logic [18:0] BASE_W_IH   = 19'h00000;
  localparam logic [18:0] BASE_W_HH   = 19'h00800;
  localparam logic [18:0] BASE_B_IH   = 19'h01800;
  localparam logic [18:0] BASE_B_HH   = 19'h01840;
  localparam logic [18:0] BASE_RESULT = 19'h02000;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;

  localparam logic [16:0] WR_COUNT_MAX = 17'h1FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/word_fifo4.sv
// rtl/word_fifo4.sv - four-entry input word FIFO with show-ahead head
module word_fifo4
  import rnn_host_if_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_push,
  input  logic [31:0] i_data,
  input  logic        i_pop,
  output logic [31:0] o_head,
  output logic        o_full,
  output logic        o_empty
);

  logic [31:0]        r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_pop;
  logic               w_push;

  assign o_full  = (r_count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];

  // A pop frees the head slot in the same cycle, so a full FIFO still takes a word then.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rnn_host_if.sv
// rtl/rnn_host_if.sv - host-side glue: SRAM region decode, input FIFO and run handshake
module rnn_host_if
  import rnn_host_if_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        host_start,
  input  logic [10:0] host_seq_len,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        ready,
  input  logic        busy,
  input  logic        i_en,
  output logic [31:0] idata,
  input  logic        mce,
  input  logic [2:0]  msel,
  input  logic [16:0] maddr,
  input  logic [19:0] mdata_w,
  output logic [19:0] mdata_r,
  output logic        sram_ce,
  output logic        sram_we,
  output logic [18:0] sram_addr,
  output logic [19:0] sram_wdata,
  input  logic [19:0] sram_rdata,
  output logic        done,
  output logic [16:0] wr_count,
  output logic        err
);

  state_t      r_state;
  state_t      w_next;
  logic        w_start;
  logic        w_req_read;
  logic        w_req_write;
  logic        w_req_tcnt;
  logic        w_req_inval;
  logic [31:0] w_fifo_head;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_pop;
  logic        r_rd_pend;
  logic [19:0] r_mdata;
  logic [31:0] r_idata;
  logic        r_err;
  logic [16:0] r_wr_count;

  word_fifo4 u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (in_valid),
    .i_data  (in_data),
    .i_pop   (i_en),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign in_ready = !w_fifo_full;
  assign w_pop    = i_en && !w_fifo_empty;

  always_comb begin
    w_req_read  = 1'b0;
    w_req_write = 1'b0;
    w_req_tcnt  = 1'b0;
    w_req_inval = 1'b0;
    sram_addr   = '0;
    if (mce) begin
      case (msel)
        MSEL_W_IH:   begin w_req_read = 1'b1; sram_addr = BASE_W_IH + {8'b0, maddr[10:0]}; end
        MSEL_W_HH:   begin w_req_read = 1'b1; sram_addr = BASE_W_HH + {7'b0, maddr[11:0]}; end
        MSEL_B_IH:   begin w_req_read = 1'b1; sram_addr = BASE_B_IH + {13'b0, maddr[5:0]}; end
        MSEL_B_HH:   begin w_req_read = 1'b1; sram_addr = BASE_B_HH + {13'b0, maddr[5:0]}; end
        MSEL_RESULT: begin w_req_write = 1'b1; sram_addr = BASE_RESULT + {2'b0, maddr}; end
        MSEL_TCNT:   w_req_tcnt = 1'b1;
        default:     w_req_inval = 1'b1;
      endcase
    end
  end

  assign sram_ce    = w_req_read || w_req_write;
  assign sram_we    = w_req_write;
  assign sram_wdata = mdata_w;

  // SRAM data arrives a cycle after the request; pass it straight through, then hold it.
  assign mdata_r  = r_rd_pend ? sram_rdata : r_mdata;
  assign idata    = r_idata;
  assign err      = r_err;
  assign wr_count = r_wr_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_pend  <= 1'b0;
      r_mdata    <= '0;
      r_idata    <= '0;
      r_err      <= 1'b0;
      r_wr_count <= '0;
    end else begin
      r_rd_pend <= w_req_read;
      if (r_rd_pend)   r_mdata <= sram_rdata;
      if (w_req_tcnt)  r_mdata <= {9'b0, host_seq_len};
      if (w_req_inval) r_mdata <= '0;
      if (w_pop) r_idata <= w_fifo_head;
      if (w_req_inval || (i_en && w_fifo_empty)) r_err <= 1'b1;
      if (w_start) r_wr_count <= '0;
      else if (w_req_write && r_wr_count != WR_COUNT_MAX) r_wr_count <= r_wr_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (host_start) w_next = ST_ARM;
      ST_ARM:  if (busy)       w_next = ST_RUN;
      ST_RUN:  if (!busy)      w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are gated by reset so an abort mid-run never shows a done pulse.
  always_comb begin
    ready   = 1'b0;
    done    = 1'b0;
    w_start = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_IDLE: w_start = host_start;
        ST_ARM:  ready   = 1'b1;
        ST_RUN:  done    = !busy;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rnn_host_if.sv
// tb/tb_rnn_host_if.sv - scoreboard bench for rnn_host_if against a behavioural model
module tb_rnn_host_if;

  logic        clk;
  logic        reset;
  logic        host_start;
  logic [10:0] host_seq_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        ready;
  logic        busy;
  logic        i_en;
  logic [31:0] idata;
  logic        mce;
  logic [2:0]  msel;
  logic [16:0] maddr;
  logic [19:0] mdata_w;
  logic [19:0] mdata_r;
  logic        sram_ce;
  logic        sram_we;
  logic [18:0] sram_addr;
  logic [19:0] sram_wdata;
  logic [19:0] sram_rdata;
  logic        done;
  logic [16:0] wr_count;
  logic        err;

  rnn_host_if dut (
    .clk(clk), .reset(reset), .host_start(host_start), .host_seq_len(host_seq_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ready(ready), .busy(busy), .i_en(i_en), .idata(idata),
    .mce(mce), .msel(msel), .maddr(maddr), .mdata_w(mdata_w), .mdata_r(mdata_r),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .done(done), .wr_count(wr_count), .err(err)
  );

  localparam int S_CE = 0, S_WE = 1, S_ADDR = 2, S_WDATA = 3, S_READY = 4, S_DONE = 5;
  localparam int S_INRDY = 6, S_MDATA = 7, S_IDATA = 8, S_ERR = 9, S_WRCNT = 10;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t        sq[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          finishing = 0;

  int          m_state;
  int          m_wr;
  bit          m_err;
  logic [19:0] m_mdata;
  logic [31:0] m_idata;
  logic [31:0] fq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every SRAM word holds a fixed function of its address, so a wrong address reads wrong data.
  function automatic logic [19:0] sram_f(input logic [18:0] a);
    return {a[9:0], a[18:9]} ^ 20'hA5C3F;
  endfunction

  always @(posedge clk) begin
    if (sram_ce && !sram_we) sram_rdata <= sram_f(sram_addr);
    else                     sram_rdata <= 20'($urandom);
  end

  function automatic string sig_name(input int s);
    case (s)
      S_CE: return "sram_ce";     S_WE: return "sram_we";     S_ADDR: return "sram_addr";
      S_WDATA: return "sram_wdata"; S_READY: return "ready";  S_DONE: return "done";
      S_INRDY: return "in_ready"; S_MDATA: return "mdata_r";  S_IDATA: return "idata";
      S_ERR: return "err";        default: return "wr_count";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int s);
    case (s)
      S_CE: return {31'b0, sram_ce};      S_WE: return {31'b0, sram_we};
      S_ADDR: return {13'b0, sram_addr};  S_WDATA: return {12'b0, sram_wdata};
      S_READY: return {31'b0, ready};     S_DONE: return {31'b0, done};
      S_INRDY: return {31'b0, in_ready};  S_MDATA: return {12'b0, mdata_r};
      S_IDATA: return idata;              S_ERR: return {31'b0, err};
      default: return {15'b0, wr_count};
    endcase
  endfunction

  task automatic push_exp(input int c, input int s, input logic [31:0] v);
    exp_t e;
    e.cyc = c; e.sig = s; e.val = v;
    sq.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = sq.pop_front();
      act = actual(e.sig);
      checks++;
      if (e.cyc != cyc || act !== e.val) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", sig_name(e.sig), e.cyc, act, e.val);
      end
    end
    if (finishing) begin
      checks++;
      if (sq.size() != 0) begin
        errors++;
        $display("FAIL drain pending=%0d exp=0", sq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic idle_inputs();
    reset = 0; host_start = 0; in_valid = 0; in_data = 0; busy = 0;
    i_en = 0; mce = 0; msel = 0; maddr = 0; mdata_w = 0;
  endtask

  // Applies the current inputs for one cycle, predicting outputs from the region/FIFO/run rules.
  task automatic step();
    int c, a;
    bit ce, we, popped, full;
    c = cyc; a = 0; ce = 0; we = 0;
    if (reset) begin
      push_exp(c, S_READY, 0);
      push_exp(c, S_DONE, 0);
      m_state = 0; m_wr = 0; m_err = 0; m_mdata = 0; m_idata = 0;
      fq.delete();
    end else begin
      if (mce) begin
        case (msel)
          3'd0: begin ce = 1; a = int'(maddr) % 2048; end
          3'd2: begin ce = 1; a = 'h800 + int'(maddr) % 4096; end
          3'd1: begin ce = 1; a = 'h1800 + int'(maddr) % 64; end
          3'd3: begin ce = 1; a = 'h1840 + int'(maddr) % 64; end
          3'd5: begin ce = 1; we = 1; a = 'h2000 + int'(maddr); end
          default: ;
        endcase
      end
      push_exp(c, S_CE, ce);
      push_exp(c, S_WE, we);
      if (ce) push_exp(c, S_ADDR, a);
      if (we) push_exp(c, S_WDATA, mdata_w);
      push_exp(c, S_READY, m_state == 1);
      push_exp(c, S_DONE, m_state == 2 && !busy);
      push_exp(c, S_INRDY, fq.size() < 4);
      if (mce) begin
        if (ce && !we)      m_mdata = sram_f(a[18:0]);
        else if (msel == 4) m_mdata = {9'b0, host_seq_len};
        else if (msel >= 6) begin m_mdata = 0; m_err = 1; end
      end
      if (m_state == 0 && host_start) m_wr = 0;
      else if (mce && msel == 5 && m_wr < 'h1FFFF) m_wr++;
      popped = i_en && fq.size() > 0;
      full   = fq.size() == 4;
      if (popped)    m_idata = fq.pop_front();
      else if (i_en) m_err = 1;
      if (in_valid && (!full || popped)) fq.push_back(in_data);
      case (m_state)
        0: if (host_start) m_state = 1;
        1: if (busy)       m_state = 2;
        default: if (!busy) m_state = 0;
      endcase
    end
    push_exp(c + 1, S_MDATA, m_mdata);
    push_exp(c + 1, S_IDATA, m_idata);
    push_exp(c + 1, S_ERR, m_err);
    push_exp(c + 1, S_WRCNT, m_wr);
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    host_seq_len = 11'd9;
    reset = 1;
    @(posedge clk); #1;
    step(); step();
    reset = 0;
    step();
    // W_hh read, t_count read, result write
    mce = 1; msel = 3'b010; maddr = 17'h00005; step();
    idle_inputs(); step();
    mce = 1; msel = 3'b100; step();
    idle_inputs(); step();
    mce = 1; msel = 3'b101; maddr = 17'h00041; mdata_w = 20'hF0000; step();
    idle_inputs(); step();
    // Fill, push-while-full-and-popping, drain, underflow
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = 32'hA0 + 32'(i); step();
    end
    in_valid = 1; in_data = 32'hE0; i_en = 1; step();
    in_valid = 0;
    for (int i = 0; i < 5; i++) step();
    idle_inputs(); step();
    // Run handshake and invalid region
    host_start = 1; step();
    host_start = 0; step(); step(); step();
    busy = 1; step(); step(); step();
    busy = 0; step(); step();
    mce = 1; msel = 3'b111; step();
    idle_inputs(); step();
    // Reset while running: no done pulse
    host_start = 1; step();
    host_start = 0; busy = 1; step(); step();
    busy = 0; reset = 1; step();
    reset = 0; step(); step();
    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom % 100) == 0;
      host_start = ($urandom % 16) == 0;
      if (($urandom % 6) == 0) busy = !busy;
      host_seq_len = 11'($urandom);
      in_valid   = $urandom % 2;
      in_data    = $urandom;
      i_en       = ($urandom % 3) == 0;
      mce        = !reset && ($urandom % 2);
      msel       = 3'($urandom);
      if (msel >= 3'd6 && ($urandom % 8) != 0) msel = 3'd0;
      maddr      = 17'($urandom);
      mdata_w    = 20'($urandom);
      step();
    end
    idle_inputs(); step(); step();
    @(negedge clk); @(negedge clk);
    finishing = 1;
  end

endmodule
